// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive path.
//   UART_DATA_W     : width of one received character
//   UART_ENTRY_W    : width of one queued entry, {error flag, data}
//   UART_FIFO_DEPTH : default number of entries in the receive queue
//   uart_entry_t    : packed view of one queued entry
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_ENTRY_W    = UART_DATA_W + 1;
  localparam int UART_FIFO_DEPTH = 8;

  // The error flag sits in the top bit so the packed entry reads as
  // {perr, data}, matching the order the receiver hands them over.
  typedef struct packed {
    logic                   perr;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// ---------------------------------------------------------------------------
// uart_fifo_ram
// Entry storage for the receive queue: DEPTH words of UART_ENTRY_W bits,
// one synchronous write port and one asynchronous read port. Contents are
// deliberately left unreset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [UART_ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [UART_ENTRY_W-1:0] rdata_o
);

  logic [UART_ENTRY_W-1:0] mem [DEPTH];

  // Plain write port with no reset: the control logic decides which words
  // are live, so stale contents are never observable as valid data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read gives the first-word fall-through behaviour the
  // consumer relies on.
  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive queue sitting between the UART receiver and its consumer. Stores
// each received byte together with its parity/framing error flag, presents
// the oldest entry combinationally, and records a sticky overrun when a byte
// arrives while the queue is full and nothing is being popped.
//   clk         : clock, all state on the rising edge
//   rst         : asynchronous active-high reset
//   rx_valid    : one-cycle strobe, new byte from the receiver
//   rx_data     : received byte
//   rx_perr     : error flag for that byte
//   rd_en       : consumer pop request
//   rd_data     : head byte (don't-care while empty)
//   rd_perr     : head error flag
//   empty       : no entries held
//   full        : DEPTH entries held
//   almost_full : count >= AF_LEVEL
//   count       : current occupancy
//   overrun     : sticky, a byte was dropped on a full queue
//   ovr_clr     : one-cycle strobe clearing overrun
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [UART_DATA_W-1:0]   rx_data,
  input  logic                     rx_perr,
  input  logic                     rd_en,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     rd_perr,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          wrEn, popEn;
  uart_entry_t   wrEntry, rdEntry;

  // A pop needs something to pop. A write needs a free slot, but a slot
  // being freed by a pop in the same cycle counts as free, so a full queue
  // that is read and written together keeps flowing instead of dropping.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    popEn     = rd_en && (count_q != '0);
    wrEn      = rx_valid && ((count_q != DEPTH_C) || popEn);
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (wrEn) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({wrEn, popEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (rx_valid && !wrEn) begin
      overrun_d = 1'b1;
    end
  end

  // Control state only; storage is not reset, so clearing the pointers and
  // count is what makes previously queued bytes unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign wrEntry = '{perr: rx_perr, data: rx_data};

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wrEn),
    .waddr_i (wrPtr_q),
    .wdata_i (wrEntry),
    .raddr_i (rdPtr_q),
    .rdata_o (rdEntry)
  );

  // Status flags are pure decodes of the count register, so they change on
  // exactly the same edge as count.
  assign rd_data     = rdEntry.data;
  assign rd_perr     = rdEntry.perr;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH=8, AF_LEVEL=6). A vector table
// drives the main push/pop/overrun scenarios with hand-derived flag values;
// a scoreboard queue tracks the bytes that should be in the queue and checks
// the head after every step. Hand-written sequences cover pointer wrap,
// set-wins overrun and reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [3:0] count;
  logic       overrun;
  logic       ovr_clr;

  int checks = 0;
  int fails  = 0;

  logic [8:0] sb [$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       p;
    logic       rd;
    logic       clr;
    logic       eEmpty;
    logic       eFull;
    logic       eAf;
    logic [3:0] eCnt;
    logic       eOvr;
  } vec_t;

  vec_t vecs [$];

  uart_rx_fifo #(
    .DEPTH    (8),
    .AF_LEVEL (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_perr     (rx_perr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_perr     (rd_perr),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags follow from an expected occupancy for DEPTH=8, AF_LEVEL=6.
  task automatic checkFlags(input string tag, input int eCnt, input logic eOvr);
    checkOutput({tag, ".count"}, 16'(count), 16'(eCnt));
    checkOutput({tag, ".empty"}, 16'(empty), 16'(eCnt == 0));
    checkOutput({tag, ".full"}, 16'(full), 16'(eCnt == 8));
    checkOutput({tag, ".af"}, 16'(almost_full), 16'(eCnt >= 6));
    checkOutput({tag, ".ovr"}, 16'(overrun), 16'(eOvr));
  endtask

  // Drive one cycle of inputs at the falling edge, predict acceptance from
  // the scoreboard occupancy, then sample just after the rising edge and
  // compare the head entry against the scoreboard.
  task automatic applyStimulus(input string tag, input logic v, input logic [7:0] d,
                               input logic p, input logic rd, input logic clr);
    bit doPop;
    bit doWr;
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    rx_perr  = p;
    rd_en    = rd;
    ovr_clr  = clr;
    doPop = rd && (sb.size() > 0);
    doWr  = v && ((sb.size() < 8) || doPop);
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    ovr_clr  = 1'b0;
    if (doPop) void'(sb.pop_front());
    if (doWr) sb.push_back({p, d});
    if (sb.size() > 0) begin
      checkOutput({tag, ".head"}, 16'({rd_perr, rd_data}), 16'(sb[0]));
    end
  endtask

  function automatic vec_t mk(logic v, logic [7:0] d, logic p, logic rd, logic clr,
                              logic eE, logic eF, logic eA, logic [3:0] eC, logic eO);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.rd = rd; r.clr = clr;
    r.eEmpty = eE; r.eFull = eF; r.eAf = eA; r.eCnt = eC; r.eOvr = eO;
    return r;
  endfunction

  initial begin
    logic [7:0] b;
    logic       bp;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_perr  = 1'b0;
    rd_en    = 1'b0;
    ovr_clr  = 1'b0;

    //              v  data   p  rd clr  emp ful af cnt ovr
    vecs.push_back(mk(1, 8'h5A, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 8'h03, 1, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0,  0, 0, 0, 4, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 0,  0, 0, 0, 5, 0));
    vecs.push_back(mk(1, 8'h06, 0, 0, 0,  0, 0, 1, 6, 0));
    vecs.push_back(mk(1, 8'h07, 0, 0, 0,  0, 0, 1, 7, 0));
    vecs.push_back(mk(1, 8'h08, 0, 0, 0,  0, 1, 1, 8, 0));
    vecs.push_back(mk(1, 8'hAA, 0, 0, 0,  0, 1, 1, 8, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1,  0, 1, 1, 8, 0));
    vecs.push_back(mk(1, 8'h77, 0, 1, 0,  0, 1, 1, 8, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 7, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 1, 6, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 5, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 4, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h33, 0, 1, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0,  1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkFlags("reset", 0, 1'b0);

    // Main table, head data checked through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      applyStimulus(t, vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].rd, vecs[i].clr);
      checkOutput({t, ".empty"}, 16'(empty), 16'(vecs[i].eEmpty));
      checkOutput({t, ".full"}, 16'(full), 16'(vecs[i].eFull));
      checkOutput({t, ".af"}, 16'(almost_full), 16'(vecs[i].eAf));
      checkOutput({t, ".count"}, 16'(count), 16'(vecs[i].eCnt));
      checkOutput({t, ".ovr"}, 16'(overrun), 16'(vecs[i].eOvr));
    end

    // Pointer wrap: keep one entry resident and stream 20 push+pop cycles.
    applyStimulus("wrap.pre", 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    checkFlags("wrap.pre", 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      b  = 8'($urandom_range(0, 255));
      bp = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("wrap%0d", i), 1'b1, b, bp, 1'b1, 1'b0);
      checkFlags($sformatf("wrap%0d", i), 1, 1'b0);
    end
    applyStimulus("wrap.drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkFlags("wrap.drain", 0, 1'b0);

    // Fill, then an overrun coinciding with ovr_clr: the set must win.
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("fill%0d", i), 1'b1, 8'(8'h90 + i), 1'(i[0]), 1'b0, 1'b0);
      checkFlags($sformatf("fill%0d", i), i + 1, 1'b0);
    end
    applyStimulus("setwins", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checkFlags("setwins", 8, 1'b1);
    applyStimulus("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkFlags("clr", 8, 1'b0);
    applyStimulus("ovr2", 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
    checkFlags("ovr2", 8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("pre%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checkFlags($sformatf("pre%0d", i), 7 - i, 1'b1);
    end

    // Asynchronous reset mid-cycle with count=5 and overrun set.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkFlags("midrst", 0, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    checkFlags("post", 1, 1'b0);
    applyStimulus("post.pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkFlags("post.pop", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, 4..16.
REQ-002 Parameter AF_LEVEL, default 6, almost-full threshold in entries.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port rx_valid  input  1  one-cycle strobe from UART receiver: new byte available.
REQ-006 Port rx_data  input  8  received byte, valid with rx_valid.
REQ-007 Port rx_perr  input  1  parity/framing error flag for that byte, valid with rx_valid.
REQ-008 Port rd_en  input  1  consumer pop request.
REQ-009 Port rd_data  output  8  head-of-queue byte, first-word fall-through.
REQ-010 Port rd_perr  output  1  error flag stored with the head byte.
REQ-011 Port empty  output  1  queue holds no entries.
REQ-012 Port full  output  1  queue holds DEPTH entries.
REQ-013 Port almost_full  output  1  count >= AF_LEVEL.
REQ-014 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 Port overrun  output  1  sticky: a byte was dropped because the queue was full.
REQ-016 Port ovr_clr  input  1  one-cycle strobe that clears overrun.

Function
REQ-017 Each entry SHALL be 9 bits: {rx_perr, rx_data}, written on the clk edge where rx_valid=1 and a slot is available.
REQ-018 rd_data/rd_perr SHALL present the oldest entry combinationally from storage whenever empty=0; value is don't-care when empty=1.
REQ-019 A pop SHALL occur on a clk edge where rd_en=1 and empty=0; rd_en while empty SHALL be ignored with no state change.
REQ-020 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 count SHALL be an explicit register: +1 on write only, -1 on pop only, unchanged on both or neither.
REQ-022 empty, full and almost_full SHALL be registered-equivalent decodes of count (no extra latency versus count).
REQ-023 Latency: a byte written at edge N SHALL be visible on rd_data and empty SHALL be 0 after edge N.
REQ-024 Full with rx_valid=1 and rd_en=1 in the same cycle: pop and write both SHALL occur, count stays DEPTH, overrun unaffected.
REQ-025 Empty with rx_valid=1 and rd_en=1: write SHALL occur, pop SHALL be ignored, count becomes 1.
REQ-026 Full with rx_valid=1 and rd_en=0: byte SHALL be dropped, storage and pointers unchanged, overrun set to 1.
REQ-027 overrun SHALL remain 1 until ovr_clr=1; if ovr_clr and a new overrun event coincide, overrun SHALL be 1 (set wins).
REQ-028 rx_valid held high for multiple cycles SHALL write one entry per cycle (no edge detection inside this block).

Reset
REQ-029 rst=1 SHALL immediately and asynchronously clear pointers, count and overrun: empty=1, full=0, almost_full=0, count=0, overrun=0.
REQ-030 Storage array contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; first write after release lands at index 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8, the entry width constant (9) and the default FIFO depth.
REQ-033 Storage SHALL be a sub-module uart_fifo_ram (DEPTH x 9, one synchronous write port, one asynchronous read port); pointer/count/flag control lives in uart_rx_fifo.

Verification
REQ-034 Reset, then push 0x5A (perr=0) -> next cycle empty=0, count=1, rd_data=0x5A, rd_perr=0; pop -> empty=1.
REQ-035 Push 0x01..0x08 with perr on 0x03 only, then pop all -> same order, rd_perr=1 only for 0x03, full=1 after 8th push, almost_full=1 from 6th push.
REQ-036 Fill to 8, push 0xAA without pop -> overrun=1, count=8, head still 0x01; ovr_clr -> overrun=0.
REQ-037 Full, simultaneous push 0x77 and pop -> count=8, overrun=0, 0x77 read out last after 7 pops.
REQ-038 Empty, simultaneous push 0x33 and pop -> count=1, rd_data=0x33; 20 push/pop cycles exercise pointer wrap with no data corruption.
REQ-039 Assert rst with count=5 and overrun=1 -> all flags at reset values within the same cycle, prior data never reappears.
